// File: rtl/bp_update_controller.sv
// Port arbiter and sequencer for a BHT of 2-bit saturating counters: init sweep after reset,
// then shares the table port between fetch lookups and queued read-modify-write updates.
module bp_update_controller #(
    parameter int unsigned IDX_BITS = 4,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_req,
    input  logic [15:0]         fetch_pc,
    output logic                fetch_pred,
    output logic                fetch_stall,
    input  logic                res_valid,
    input  logic [15:0]         res_pc,
    input  logic                res_taken,
    output logic                res_ready,
    output logic [IDX_BITS-1:0] tbl_addr,
    output logic                tbl_we,
    output logic [1:0]          tbl_wdata,
    input  logic [1:0]          tbl_rdata,
    output logic                init_busy
);

    localparam int unsigned PtrW = $clog2(QDEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic {StInit, StRun} state_e;

    state_e              state_q, state_d;
    logic [IDX_BITS-1:0] init_idx_q, init_idx_d;
    logic [IDX_BITS-1:0] fifo_idx_q [QDEPTH];
    logic [QDEPTH-1:0]   fifo_taken_q;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [2:0]          age_q, age_d;

    logic                fifo_empty, fifo_full, grant_upd, push, pop;
    logic [IDX_BITS-1:0] fetch_idx, res_idx, head_idx;
    logic                head_taken;
    logic                unused_pc;

    assign fetch_idx  = fetch_pc[IDX_BITS:1];
    assign res_idx    = res_pc[IDX_BITS:1];
    assign unused_pc  = ^{fetch_pc[15:IDX_BITS+1], fetch_pc[0], res_pc[15:IDX_BITS+1], res_pc[0]};
    assign head_idx   = fifo_idx_q[rd_ptr_q];
    assign head_taken = fifo_taken_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(QDEPTH));
    assign push       = res_valid && res_ready;
    assign pop        = grant_upd;

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        age_d       = age_q;
        tbl_addr    = '0;
        tbl_we      = 1'b0;
        tbl_wdata   = 2'b01;
        fetch_pred  = 1'b0;
        fetch_stall = 1'b0;
        init_busy   = 1'b0;
        res_ready   = 1'b0;
        grant_upd   = 1'b0;
        case (state_q)
            StInit: begin
                tbl_addr    = init_idx_q;
                tbl_we      = 1'b1;
                init_busy   = 1'b1;
                fetch_stall = 1'b1;
                init_idx_d  = init_idx_q + 1'b1;
                age_d       = 3'd0;
                if (init_idx_q == '1) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                res_ready = !fifo_full;
                // A full queue or a starved head forces the update past a pending lookup.
                grant_upd = !fifo_empty && (!fetch_req || fifo_full || age_q == 3'd7);
                if (grant_upd) begin
                    tbl_addr    = head_idx;
                    tbl_we      = 1'b1;
                    fetch_stall = fetch_req;
                    age_d       = 3'd0;
                    if (head_taken) begin
                        tbl_wdata = (tbl_rdata == 2'd3) ? 2'd3 : tbl_rdata + 2'd1;
                    end else begin
                        tbl_wdata = (tbl_rdata == 2'd0) ? 2'd0 : tbl_rdata - 2'd1;
                    end
                end else begin
                    if (fetch_req) begin
                        tbl_addr   = fetch_idx;
                        fetch_pred = tbl_rdata[1];
                    end
                    if (fifo_empty) begin
                        age_d = 3'd0;
                    end else if (age_q != 3'd7) begin
                        age_d = age_q + 3'd1;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StInit;
            init_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            age_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            age_q      <= age_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx_q[wr_ptr_q]   <= res_idx;
            fifo_taken_q[wr_ptr_q] <= res_taken;
        end
    end

endmodule

// File: tb/tb_bp_update_controller.sv
// Directed bench for bp_update_controller: behavioural table, counter model and write scoreboard.
module tb_bp_update_controller;

    logic        clk = 1'b0;
    logic        rst, fetch_req, res_valid, res_taken;
    logic [15:0] fetch_pc, res_pc;
    logic        fetch_pred, fetch_stall, res_ready, tbl_we, init_busy;
    logic [3:0]  tbl_addr;
    logic [1:0]  tbl_wdata, tbl_rdata;

    typedef struct packed {logic [3:0] idx; logic [1:0] val;} exp_t;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [1:0]  mem [16];
    logic [1:0]  model [16];
    logic [3:0]  mon_idx;
    logic [9:0]  pat;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    bp_update_controller #(.IDX_BITS(4), .QDEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .fetch_pc   (fetch_pc),
        .fetch_pred (fetch_pred),
        .fetch_stall(fetch_stall),
        .res_valid  (res_valid),
        .res_pc     (res_pc),
        .res_taken  (res_taken),
        .res_ready  (res_ready),
        .tbl_addr   (tbl_addr),
        .tbl_we     (tbl_we),
        .tbl_wdata  (tbl_wdata),
        .tbl_rdata  (tbl_rdata),
        .init_busy  (init_busy)
    );

    assign tbl_rdata = mem[tbl_addr];
    always @(posedge clk) if (tbl_we) mem[tbl_addr] <= tbl_wdata;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] nxt(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
        #1;
        chk("drain", 16'(sb.size()), 16'd0);
    endtask

    // Pop before push: an entry accepted this cycle cannot be written until the next one.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            for (int i = 0; i < 16; i++) model[i] = 2'd1;
        end else begin
            if (tbl_we && !init_busy) begin
                if (sb.size() == 0) begin
                    chk("spurious_write", 16'(tbl_we), 16'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("upd_addr", 16'(tbl_addr), 16'(mon_e.idx));
                    chk("upd_wdata", 16'(tbl_wdata), 16'(mon_e.val));
                end
            end
            if (res_valid && res_ready) begin
                mon_idx = res_pc[4:1];
                model[mon_idx] = nxt(model[mon_idx], res_taken);
                sb.push_back('{idx: mon_idx, val: model[mon_idx]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; fetch_req = 1'b0; fetch_pc = '0; res_valid = 1'b0; res_pc = '0;
        res_taken = 1'b0; pat = 10'b1011001101;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", 16'(init_busy), 16'd1);
        chk("rst_stall", 16'(fetch_stall), 16'd1);
        chk("rst_ready", 16'(res_ready), 16'd0);
        chk("rst_pred", 16'(fetch_pred), 16'd0);
        for (int i = 0; i < 16; i++) begin
            chk("init_addr", 16'(tbl_addr), 16'(i));
            chk("init_we", 16'(tbl_we), 16'd1);
            chk("init_wdata", 16'(tbl_wdata), 16'd1);
            chk("init_busy", 16'(init_busy), 16'd1);
            tick(); #1;
        end
        chk("init_done", 16'(init_busy), 16'd0);
        for (int i = 0; i < 16; i++) chk("init_mem", 16'(mem[i]), 16'd1);
        fetch_req = 1'b1; fetch_pc = 16'h0006;
        #1;
        chk("lookup6_pred", 16'(fetch_pred), 16'd0);
        chk("lookup6_stall", 16'(fetch_stall), 16'd0);
        chk("lookup6_addr", 16'(tbl_addr), 16'd3);

        // Saturation up then down at pc 0x0008 (index 4)
        fetch_req = 1'b0;
        res_valid = 1'b1; res_pc = 16'h0008; res_taken = 1'b1;
        repeat (3) tick();
        res_valid = 1'b0;
        drain();
        chk("sat_up_mem", 16'(mem[4]), 16'd3);
        fetch_req = 1'b1; fetch_pc = 16'h0008;
        #1;
        chk("sat_up_pred", 16'(fetch_pred), 16'd1);
        fetch_req = 1'b0;
        res_valid = 1'b1; res_taken = 1'b0;
        repeat (4) tick();
        res_valid = 1'b0;
        drain();
        chk("sat_dn_mem", 16'(mem[4]), 16'd0);
        fetch_req = 1'b1;
        #1;
        chk("sat_dn_pred", 16'(fetch_pred), 16'd0);

        // One queued update against continuous fetch: served by the age limit
        tick();
        fetch_pc = 16'h0020;
        res_valid = 1'b1; res_pc = 16'h000A; res_taken = 1'b1;
        tick();
        res_valid = 1'b0;
        #1;
        for (int k = 1; k <= 7; k++) begin
            chk("age_fetch_stall", 16'(fetch_stall), 16'd0);
            chk("age_fetch_we", 16'(tbl_we), 16'd0);
            tick(); #1;
        end
        chk("age_upd_stall", 16'(fetch_stall), 16'd1);
        chk("age_upd_we", 16'(tbl_we), 16'd1);
        chk("age_upd_pred", 16'(fetch_pred), 16'd0);
        tick(); #1;
        chk("age_resume_stall", 16'(fetch_stall), 16'd0);
        chk("age_resume_we", 16'(tbl_we), 16'd0);

        // Fill the FIFO under continuous fetch
        for (int i = 0; i < 4; i++) begin
            res_valid = 1'b1; res_pc = 16'(2 * i + 2); res_taken = i[0];
            #1;
            chk("fill_ready", 16'(res_ready), 16'd1);
            tick();
        end
        res_valid = 1'b0;
        #1;
        chk("full_ready", 16'(res_ready), 16'd0);
        chk("full_stall", 16'(fetch_stall), 16'd1);
        chk("full_we", 16'(tbl_we), 16'd1);
        tick(); #1;
        chk("after_pop_ready", 16'(res_ready), 16'd1);
        chk("after_pop_stall", 16'(fetch_stall), 16'd0);
        fetch_req = 1'b0;
        drain();

        // Simultaneous enqueue/dequeue at count 2
        fetch_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            res_valid = 1'b1; res_pc = 16'((i % 3) * 2 + 2); res_taken = pat[i];
            if (i == 2) fetch_req = 1'b0;
            #1;
            if (i >= 2) begin
                chk("enqdeq_count", 16'(sb.size()), 16'd2);
                chk("enqdeq_we", 16'(tbl_we), 16'd1);
                chk("enqdeq_ready", 16'(res_ready), 16'd1);
            end
            tick();
        end
        res_valid = 1'b0;
        drain();

        // Reset mid-RUN with three pending updates
        fetch_req = 1'b1; fetch_pc = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1; res_pc = 16'(2 * i + 2); res_taken = 1'b1;
            tick();
        end
        res_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rerst_busy", 16'(init_busy), 16'd1);
        chk("rerst_addr", 16'(tbl_addr), 16'd0);
        chk("rerst_we", 16'(tbl_we), 16'd1);
        chk("rerst_wdata", 16'(tbl_wdata), 16'd1);
        repeat (16) tick();
        fetch_req = 1'b0;
        repeat (20) tick();
        for (int i = 0; i < 16; i++) begin
            chk("rerst_mem", 16'(mem[i]), 16'd1);
            fetch_req = 1'b1; fetch_pc = 16'(i * 2);
            #1;
            chk("rerst_pred", 16'(fetch_pred), 16'd0);
        end
        fetch_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
